demux_stream: RTL
=================

// Module: demux_stream
//
// PURPOSE
//  Registered 1-to-N stream demultiplexer: one input stream is routed to one of
//  2^SEL_BITS output channels, chosen per beat by a select field.
//  Each output channel has its own one-entry output register and its own
//  valid/ready handshake, so a stalled channel blocks only beats addressed to it.
//  It is the distribution counterpart of the registered N-to-1 select mux used in
//  the op-synthesis evaluation designs, and is measured for utilization the same way.
//
// PARAMETERS
//  SEL_BITS   1   width of select field; output channel count OUT_NUM = 1 << SEL_BITS
//  DATA_BITS  1   width of one data beat
//  OUT_NUM    1<<SEL_BITS   derived, not overridden
//
// PORTS
//  clk      in   1                   rising-edge clock
//  reset    in   1                   synchronous, active-high reset
//  cke      in   1                   clock enable; 0 freezes all state
//  s_sel    in   SEL_BITS            destination channel of the current input beat
//  s_data   in   DATA_BITS           input beat data
//  s_valid  in   1                   input beat present
//  s_ready  out  1                   input beat accepted this cycle when s_valid=1
//  m_data   out  OUT_NUM*DATA_BITS   channel i data at [i*DATA_BITS +: DATA_BITS]
//  m_valid  out  OUT_NUM             channel i holds a beat
//  m_ready  in   OUT_NUM             channel i consumer takes its beat
//  busy     out  1                   OR of m_valid
//
// BEHAVIOUR
//  - Reset (synchronous, active-high, wins over cke): m_valid=0, m_data=0, busy=0.
//    Beats held when reset is asserted are discarded.
//  - pop[i]  = cke & m_valid[i] & m_ready[i].
//  - s_ready = cke & (~m_valid[s_sel] | m_ready[s_sel]).
//    Combinational from s_sel, m_valid and m_ready. No path from s_valid to s_ready.
//  - push    = s_valid & s_ready. When push=1, channel s_sel loads s_data and
//    m_valid[s_sel] is set on the next edge.
//  - Latency: 1 cycle from accepted beat to m_valid.
//  - Throughput: 1 beat per cycle, including repeated beats to the same channel
//    while its m_ready=1.
//  - Same-channel push and pop in one cycle: m_valid stays 1 and m_data takes the
//    new beat (no bubble).
//  - Pop without push: m_valid[i] clears; m_data[i] keeps its last value.
//  - A push to channel j alongside pops on other channels is allowed. All channels
//    update independently in the same cycle.
//  - Stability: while m_valid[i]=1 and no pop, m_data[i] is held unchanged.
//  - Output data is never reordered within a channel.
//  - cke=0: no state change and s_ready=0. m_ready is ignored, so the downstream
//    must share cke. Outputs hold their values.
//  - Every s_sel value is legal because OUT_NUM = 2^SEL_BITS exactly.
//  - busy = |m_valid, registered-derived; no combinational input path.
//
// TESTING  (SEL_BITS=2, DATA_BITS=8 unless noted)
//  1. Reset: after reset, with cke=1 and m_ready=0 -> m_valid=0000, m_data=0,
//     s_ready=1, busy=0.
//  2. Routing: s_sel=2, s_data=A5, s_valid=1, m_ready=1111 -> next cycle
//     m_valid=0100, m_data[23:16]=A5; other lanes unchanged.
//  3. Backpressure: m_ready[1]=0; send 11 then 22 to s_sel=1 -> 11 accepted;
//     s_ready=0 while 22 is offered; lane 1 holds 11 stable.
//     Raise m_ready[1] -> 22 accepted the same cycle, and m_data lane 1 = 22
//     on the next edge.
//  4. Streaming: s_sel=3, m_ready[3]=1, data 00..0F on consecutive cycles
//     -> 16 beats out on lane 3 in order, no bubbles, s_ready constantly 1.
//  5. Isolation: lane 0 stalled holding 5A; beats to lanes 1/2/3 still pass at
//     1 per cycle. Lane 0 data stays 5A throughout.
//  6. cke=0 mid-stream: m_valid/m_data frozen, s_ready=0, m_ready pulses do not
//     clear valid. Reset asserted with lanes 0 and 2 valid -> m_valid=0000,
//     busy=0 next cycle.

Source files
------------

// File: rtl/demux_stream.sv
// Registered 1-to-N stream demultiplexer: each input beat is steered by s_sel into
// one of 2^SEL_BITS single-entry output registers, each with its own valid/ready.
module demux_stream #(
   parameter  int SEL_BITS  = 1,
   parameter  int DATA_BITS = 1,
   localparam int OUT_NUM   = 1 << SEL_BITS
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         cke,
   input  logic [SEL_BITS-1:0]          s_sel,
   input  logic [DATA_BITS-1:0]         s_data,
   input  logic                         s_valid,
   output logic                         s_ready,
   output logic [OUT_NUM*DATA_BITS-1:0] m_data,
   output logic [OUT_NUM-1:0]           m_valid,
   input  logic [OUT_NUM-1:0]           m_ready,
   output logic                         busy
);

   logic [OUT_NUM-1:0]           valid_q, valid_d;
   logic [OUT_NUM*DATA_BITS-1:0] data_q,  data_d;
   logic [OUT_NUM-1:0]           pop;
   logic                         push;

   assign pop = {OUT_NUM{cke}} & valid_q & m_ready;

   // Addressed slot may take a beat if empty or being drained this same cycle.
   assign s_ready = cke & (~valid_q[s_sel] | m_ready[s_sel]);
   assign push    = s_valid & s_ready;

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      for (int i = 0; i < OUT_NUM; i++) begin
         if (pop[i]) begin
            valid_d[i] = 1'b0;
         end
         if (push && (s_sel == SEL_BITS'(i))) begin
            valid_d[i]                         = 1'b1;
            data_d[i*DATA_BITS +: DATA_BITS]   = s_data;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q <= '0;
         data_q  <= '0;
      end else if (cke) begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign m_valid = valid_q;
   assign m_data  = data_q;
   assign busy    = |valid_q;

endmodule
